// File: rtl/axilite_regbank_pkg.sv
// Shared constants for the AXI-lite register bank: register modes, response codes,
// the unmapped-read pattern and the write/read FSM state encodings.
package axilite_regbank_pkg;

    localparam logic [1:0] MODE_RW    = 2'd0;
    localparam logic [1:0] MODE_RO    = 2'd1;
    localparam logic [1:0] MODE_W1C   = 2'd2;
    localparam logic [1:0] MODE_PULSE = 2'd3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [11:0] UNMAPPED_RDATA = 12'hBAD;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wstate_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rstate_e;

endpackage

// File: rtl/axilite_regbank_cell.sv
// One register with its access mode (RW, RO, W1C, PULSE); write lands on the edge we_i is high.
// No backpressure: the bank decides when we_i fires.
module axilite_regbank_cell
    import axilite_regbank_pkg::*;
#(
    parameter int         DATA_W = 32,
    parameter logic [1:0] MODE   = MODE_RW
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                we_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W/8-1:0] wstrb_i,
    input  logic [DATA_W-1:0]   hw_i,
    output logic [DATA_W-1:0]   q_o
);

    logic [DATA_W-1:0] q_q;
    logic [DATA_W-1:0] q_d;
    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] wbits;

    always_comb begin
        for (int b = 0; b < DATA_W/8; b++) begin
            mask[b*8 +: 8] = {8{wstrb_i[b]}};
        end
    end

    assign wbits = wdata_i & mask;

    // W1C: the hardware set is OR-ed in last so it beats a same-cycle clear.
    always_comb begin
        q_d = q_q;
        case (MODE)
            MODE_RW:  if (we_i) q_d = (q_q & ~mask) | wbits;
            MODE_RO:  q_d = hw_i;
            MODE_W1C: q_d = (q_q & ~(we_i ? wbits : '0)) | hw_i;
            default:  q_d = we_i ? wbits : '0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/axilite_regbank.sv
// AXI-lite register bank; write commits one edge after AW and W are both held, read data one edge after AR.
// B/R outputs hold until ready; AXILITE_REGBANK_SLVERR_EN makes unmapped accesses answer SLVERR.
module axilite_regbank
    import axilite_regbank_pkg::*;
#(
    parameter int                    ADDR_W    = 32,
    parameter int                    DATA_W    = 32,
    parameter int                    NUM_REGS  = 8,
    parameter logic [ADDR_W-1:0]     BASE_ADDR = 'h10000000,
    parameter logic [2*NUM_REGS-1:0] REG_MODE  = '0
) (
    input  logic                         aclk,
    input  logic                         areset,
    input  logic [ADDR_W-1:0]            s_axi_awaddr,
    input  logic                         s_axi_awvalid,
    output logic                         s_axi_awready,
    input  logic [DATA_W-1:0]            s_axi_wdata,
    input  logic [DATA_W/8-1:0]          s_axi_wstrb,
    input  logic                         s_axi_wvalid,
    output logic                         s_axi_wready,
    output logic [1:0]                   s_axi_bresp,
    output logic                         s_axi_bvalid,
    input  logic                         s_axi_bready,
    input  logic [ADDR_W-1:0]            s_axi_araddr,
    input  logic                         s_axi_arvalid,
    output logic                         s_axi_arready,
    output logic [DATA_W-1:0]            s_axi_rdata,
    output logic [1:0]                   s_axi_rresp,
    output logic                         s_axi_rvalid,
    input  logic                         s_axi_rready,
    output logic [NUM_REGS*DATA_W-1:0]   reg_out,
    input  logic [NUM_REGS*DATA_W-1:0]   hw_in,
    output logic [NUM_REGS-1:0]          wr_pulse
);

    localparam int SHIFT = $clog2(DATA_W/8);
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

`ifdef AXILITE_REGBANK_SLVERR_EN
    localparam logic [1:0]        UNMAPPED_RESP = RESP_SLVERR;
    localparam logic [DATA_W-1:0] UNMAPPED_DATA = '0;
`else
    localparam logic [1:0]        UNMAPPED_RESP = RESP_OKAY;
    localparam logic [DATA_W-1:0] UNMAPPED_DATA = DATA_W'(UNMAPPED_RDATA);
`endif

    function automatic logic decode_hit(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W-1:0] off;
        off = addr - BASE_ADDR;
        return (addr >= BASE_ADDR) && ((off >> SHIFT) < ADDR_W'(NUM_REGS));
    endfunction

    function automatic logic [IDX_W-1:0] decode_idx(input logic [ADDR_W-1:0] addr);
        return IDX_W'((addr - BASE_ADDR) >> SHIFT);
    endfunction

    wstate_e               wstate_q, wstate_d;
    rstate_e               rstate_q, rstate_d;
    logic                  rdy_en_q;
    logic                  aw_held_q, w_held_q;
    logic [ADDR_W-1:0]     awaddr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [DATA_W/8-1:0]   wstrb_q;
    logic [1:0]            bresp_q, rresp_q;
    logic [DATA_W-1:0]     rdata_q;
    logic [NUM_REGS-1:0]   wr_pulse_q;
    logic                  wr_commit;
    logic                  wr_hit, rd_hit;
    logic [IDX_W-1:0]      wr_idx, rd_idx;
    logic [NUM_REGS-1:0]   wr_we;
    logic [DATA_W-1:0]     rd_val;
    logic [NUM_REGS*DATA_W-1:0] regs;

    assign wr_hit = decode_hit(awaddr_q);
    assign wr_idx = decode_idx(awaddr_q);
    assign rd_hit = decode_hit(s_axi_araddr);
    assign rd_idx = decode_idx(s_axi_araddr);

    // rdy_en_q keeps every ready low through reset and raises them on the first edge after.
    always_comb begin
        wstate_d      = wstate_q;
        wr_commit     = 1'b0;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        case (wstate_q)
            W_IDLE: begin
                s_axi_awready = rdy_en_q && !aw_held_q;
                s_axi_wready  = rdy_en_q && !w_held_q;
                if (aw_held_q && w_held_q) begin
                    wr_commit = 1'b1;
                    wstate_d  = W_RESP;
                end
            end
            W_RESP: if (s_axi_bready) wstate_d = W_IDLE;
        endcase
    end

    always_comb begin
        rstate_d      = rstate_q;
        s_axi_arready = 1'b0;
        case (rstate_q)
            R_IDLE: begin
                s_axi_arready = rdy_en_q;
                if (s_axi_arvalid && rdy_en_q) rstate_d = R_DATA;
            end
            R_DATA: if (s_axi_rready) rstate_d = R_IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            wr_we[i] = wr_commit && wr_hit && (wr_idx == IDX_W'(i));
        end
    end

    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_idx == IDX_W'(i)) rd_val = regs[i*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wstate_q   <= W_IDLE;
            rstate_q   <= R_IDLE;
            rdy_en_q   <= 1'b0;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bresp_q    <= RESP_OKAY;
            rresp_q    <= RESP_OKAY;
            rdata_q    <= '0;
            wr_pulse_q <= '0;
        end else begin
            wstate_q   <= wstate_d;
            rstate_q   <= rstate_d;
            rdy_en_q   <= 1'b1;
            wr_pulse_q <= wr_we;
            if (s_axi_awvalid && s_axi_awready) begin
                aw_held_q <= 1'b1;
                awaddr_q  <= s_axi_awaddr;
            end
            if (s_axi_wvalid && s_axi_wready) begin
                w_held_q <= 1'b1;
                wdata_q  <= s_axi_wdata;
                wstrb_q  <= s_axi_wstrb;
            end
            if (wr_commit) begin
                aw_held_q <= 1'b0;
                w_held_q  <= 1'b0;
                bresp_q   <= wr_hit ? RESP_OKAY : UNMAPPED_RESP;
            end
            if (s_axi_arvalid && s_axi_arready) begin
                rdata_q <= rd_hit ? rd_val : UNMAPPED_DATA;
                rresp_q <= rd_hit ? RESP_OKAY : UNMAPPED_RESP;
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_cell
        axilite_regbank_cell #(
            .DATA_W (DATA_W),
            .MODE   (REG_MODE[2*g +: 2])
        ) u_cell (
            .clk_i   (aclk),
            .rst_i   (areset),
            .we_i    (wr_we[g]),
            .wdata_i (wdata_q),
            .wstrb_i (wstrb_q),
            .hw_i    (hw_in[g*DATA_W +: DATA_W]),
            .q_o     (regs[g*DATA_W +: DATA_W])
        );
    end

    assign reg_out      = regs;
    assign wr_pulse     = wr_pulse_q;
    assign s_axi_bvalid = (wstate_q == W_RESP);
    assign s_axi_bresp  = bresp_q;
    assign s_axi_rvalid = (rstate_q == R_DATA);
    assign s_axi_rdata  = rdata_q;
    assign s_axi_rresp  = rresp_q;

endmodule

// File: tb/tb_axilite_regbank.sv
// Directed bench for axilite_regbank: a vector table of single accesses plus hand sequences
// for write ordering, W1C/PULSE timing, read/write collision and mid-read reset.
module tb_axilite_regbank;

    localparam logic [31:0] BASE = 32'h1000_0000;
`ifdef AXILITE_REGBANK_SLVERR_EN
    localparam logic [1:0]  UNM_RESP = 2'b10;
    localparam logic [31:0] UNM_DATA = 32'h0;
`else
    localparam logic [1:0]  UNM_RESP = 2'b00;
    localparam logic [31:0] UNM_DATA = 32'h0000_0BAD;
`endif

    logic         aclk = 1'b0;
    logic         areset = 1'b1;
    logic [31:0]  s_axi_awaddr = '0;
    logic         s_axi_awvalid = 1'b0;
    logic         s_axi_awready;
    logic [31:0]  s_axi_wdata = '0;
    logic [3:0]   s_axi_wstrb = '0;
    logic         s_axi_wvalid = 1'b0;
    logic         s_axi_wready;
    logic [1:0]   s_axi_bresp;
    logic         s_axi_bvalid;
    logic         s_axi_bready = 1'b0;
    logic [31:0]  s_axi_araddr = '0;
    logic         s_axi_arvalid = 1'b0;
    logic         s_axi_arready;
    logic [31:0]  s_axi_rdata;
    logic [1:0]   s_axi_rresp;
    logic         s_axi_rvalid;
    logic         s_axi_rready = 1'b0;
    logic [255:0] reg_out;
    logic [255:0] hw_in = '0;
    logic [7:0]   wr_pulse;

    int checks = 0;
    int failures = 0;

    always #5 aclk = ~aclk;

    axilite_regbank #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .NUM_REGS  (8),
        .BASE_ADDR (32'h1000_0000),
        .REG_MODE  (16'h01E0)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .reg_out       (reg_out),
        .hw_in         (hw_in),
        .wr_pulse      (wr_pulse)
    );

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s timeout actual=no_handshake expected=handshake", name);
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp);
        bit aw_done, w_done, aw_hs, w_hs;
        int n;
        s_axi_awaddr  = addr;
        s_axi_wdata   = data;
        s_axi_wstrb   = strb;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        aw_done = 0;
        w_done  = 0;
        n = 0;
        while (!(aw_done && w_done) && n < 20) begin
            aw_hs = s_axi_awvalid && s_axi_awready;
            w_hs  = s_axi_wvalid && s_axi_wready;
            tick();
            if (aw_hs) begin s_axi_awvalid = 1'b0; aw_done = 1; end
            if (w_hs)  begin s_axi_wvalid  = 1'b0; w_done  = 1; end
            n++;
        end
        if (!(aw_done && w_done)) timeout("write_addr_data");
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        s_axi_bready  = 1'b1;
        n = 0;
        while (!s_axi_bvalid && n < 20) begin tick(); n++; end
        resp = s_axi_bresp;
        if (!s_axi_bvalid) timeout("write_bvalid");
        tick();
        s_axi_bready = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int n;
        s_axi_araddr  = addr;
        s_axi_arvalid = 1'b1;
        n = 0;
        while (!s_axi_arready && n < 20) begin tick(); n++; end
        if (!s_axi_arready) timeout("read_arready");
        tick();
        s_axi_arvalid = 1'b0;
        s_axi_rready  = 1'b1;
        n = 0;
        while (!s_axi_rvalid && n < 20) begin tick(); n++; end
        if (!s_axi_rvalid) timeout("read_rvalid");
        data = s_axi_rdata;
        resp = s_axi_rresp;
        tick();
        s_axi_rready = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic [1:0]  rsp;

        vecs[0]  = '{1'b1, BASE,          32'h1234_5678, 4'hF, 32'h0,          2'b00};
        vecs[1]  = '{1'b0, BASE,          32'h0,         4'h0, 32'h1234_5678,  2'b00};
        vecs[2]  = '{1'b1, BASE + 32'h2,  32'hFFFF_FFFF, 4'h8, 32'h0,          2'b00};
        vecs[3]  = '{1'b0, BASE + 32'h3,  32'h0,         4'h0, 32'hFF34_5678,  2'b00};
        vecs[4]  = '{1'b1, BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0,          2'b00};
        vecs[5]  = '{1'b0, BASE + 32'h10, 32'h0,         4'h0, 32'h0000_5A5A,  2'b00};
        vecs[6]  = '{1'b1, BASE + 32'h1C, 32'hCAFE_F00D, 4'hF, 32'h0,          2'b00};
        vecs[7]  = '{1'b0, BASE + 32'h1C, 32'h0,         4'h0, 32'hCAFE_F00D,  2'b00};
        vecs[8]  = '{1'b0, BASE + 32'h20, 32'h0,         4'h0, UNM_DATA,       UNM_RESP};
        vecs[9]  = '{1'b0, 32'h0FFF_FFFC, 32'h0,         4'h0, UNM_DATA,       UNM_RESP};
        vecs[10] = '{1'b1, BASE + 32'h1C, 32'h0000_FFFF, 4'h3, 32'h0,          2'b00};
        vecs[11] = '{1'b0, BASE + 32'h1C, 32'h0,         4'h0, 32'hCAFE_FFFF,  2'b00};

        // Reset behaviour
        repeat (3) tick();
        check("rst_awready", s_axi_awready, 0);
        check("rst_arready", s_axi_arready, 0);
        areset = 1'b0;
        tick();
        check("rel_awready", s_axi_awready, 1);
        check("rel_wready",  s_axi_wready,  1);
        check("rel_arready", s_axi_arready, 1);
        check("rel_bvalid",  s_axi_bvalid,  0);
        check("rel_rvalid",  s_axi_rvalid,  0);
        check("rel_reg_out", reg_out[255:0] == '0, 1);

        hw_in[4*32 +: 32] = 32'h0000_5A5A;

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].wr) begin
                do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, rsp);
                check($sformatf("vec%0d_bresp", i), rsp, vecs[i].exp_resp);
            end else begin
                do_read(vecs[i].addr, rd, rsp);
                check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_data);
                check($sformatf("vec%0d_rresp", i), rsp, vecs[i].exp_resp);
            end
        end

        // W leads AW by three cycles on reg1 (RW)
        s_axi_wdata  = 32'hA5A5_A5A5;
        s_axi_wstrb  = 4'b0101;
        s_axi_wvalid = 1'b1;
        check("wfirst_wready", s_axi_wready, 1);
        tick();
        s_axi_wvalid = 1'b0;
        tick();
        tick();
        check("wheld_wready",  s_axi_wready,  0);
        check("wheld_awready", s_axi_awready, 1);
        check("wheld_bvalid",  s_axi_bvalid,  0);
        s_axi_awaddr  = BASE + 32'h4;
        s_axi_awvalid = 1'b1;
        tick();
        s_axi_awvalid = 1'b0;
        check("aw_taken_bvalid", s_axi_bvalid, 0);
        tick();
        check("commit_bvalid", s_axi_bvalid, 1);
        check("commit_bresp",  s_axi_bresp, 2'b00);
        check("commit_reg1",   reg_out[32 +: 32], 32'h00A5_00A5);
        check("commit_pulse",  wr_pulse, 8'h02);
        tick();
        check("pulse_gone",    wr_pulse, 8'h00);
        check("bvalid_held",   s_axi_bvalid, 1);
        s_axi_bready = 1'b1;
        tick();
        s_axi_bready = 1'b0;
        check("bdone_bvalid",  s_axi_bvalid, 0);
        check("bdone_awready", s_axi_awready, 1);
        check("bdone_wready",  s_axi_wready, 1);

        // W1C on reg2
        hw_in[64] = 1'b1;
        tick();
        hw_in[64] = 1'b0;
        check("w1c_set", reg_out[64 +: 32], 32'h1);
        tick();
        check("w1c_sticky", reg_out[64 +: 32], 32'h1);
        do_write(BASE + 32'h8, 32'h1, 4'hF, rsp);
        check("w1c_clear", reg_out[64 +: 32], 32'h0);
        s_axi_awaddr = BASE + 32'h8; s_axi_wdata = 32'h1; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        tick();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        hw_in[64] = 1'b1;
        tick();
        hw_in[64] = 1'b0;
        check("w1c_set_wins", reg_out[64 +: 32], 32'h1);
        s_axi_bready = 1'b1;
        tick();
        s_axi_bready = 1'b0;
        check("w1c_after", reg_out[64 +: 32], 32'h1);

        // PULSE on reg3
        s_axi_awaddr = BASE + 32'hC; s_axi_wdata = 32'h8; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        tick();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        check("pulse_before", reg_out[96 +: 32], 32'h0);
        tick();
        check("pulse_on",     reg_out[96 +: 32], 32'h8);
        check("pulse_strobe", wr_pulse, 8'h08);
        tick();
        check("pulse_off",    reg_out[96 +: 32], 32'h0);
        s_axi_bready = 1'b1;
        tick();
        s_axi_bready = 1'b0;
        do_read(BASE + 32'hC, rd, rsp);
        check("pulse_read", rd, 32'h0);

        // Read and write of reg0 on the same edge
        s_axi_awaddr = BASE; s_axi_wdata = 32'hAAAA_5555; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        tick();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        s_axi_araddr = BASE; s_axi_arvalid = 1'b1;
        tick();
        s_axi_arvalid = 1'b0;
        check("coll_rvalid", s_axi_rvalid, 1);
        check("coll_bvalid", s_axi_bvalid, 1);
        check("coll_rdata",  s_axi_rdata, 32'hFF34_5678);
        check("coll_reg0",   reg_out[0 +: 32], 32'hAAAA_5555);
        s_axi_bready = 1'b1; s_axi_rready = 1'b1;
        tick();
        s_axi_bready = 1'b0; s_axi_rready = 1'b0;
        check("coll_rdone", s_axi_rvalid, 0);
        check("coll_bdone", s_axi_bvalid, 0);

        // Unmapped write
        s_axi_awaddr = BASE + 32'h20; s_axi_wdata = 32'hFFFF_FFFF; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        tick();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        tick();
        check("unm_bvalid", s_axi_bvalid, 1);
        check("unm_bresp",  s_axi_bresp, UNM_RESP);
        check("unm_pulse",  wr_pulse, 8'h00);
        s_axi_bready = 1'b1;
        tick();
        s_axi_bready = 1'b0;
        check("unm_reg0", reg_out[0 +: 32], 32'hAAAA_5555);
        check("unm_reg7", reg_out[224 +: 32], 32'hCAFE_FFFF);

        // Reset while a read response is pending
        s_axi_araddr = BASE + 32'h4; s_axi_arvalid = 1'b1;
        tick();
        s_axi_arvalid = 1'b0;
        check("pend_rvalid", s_axi_rvalid, 1);
        check("pend_rdata",  s_axi_rdata, 32'h00A5_00A5);
        #2;
        areset = 1'b1;
        #1;
        check("arst_rvalid",  s_axi_rvalid, 0);
        check("arst_arready", s_axi_arready, 0);
        check("arst_rdata",   s_axi_rdata, 32'h0);
        check("arst_reg1",    reg_out[32 +: 32], 32'h0);
        #3;
        areset = 1'b0;
        tick();
        check("arst_rel_arready", s_axi_arready, 1);
        do_read(BASE + 32'h4, rd, rsp);
        check("arst_read_data", rd, 32'h0);
        check("arst_read_resp", rsp, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
